// File: rtl/arb_req_pkg.sv
// Shared types and constants for the arbiter requester front end (arb_req_gen).
package arb_req_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int ERR_MULTI_GNT = 0;
  localparam int ERR_IDLE_GNT  = 1;
  localparam int ERR_OVERFLOW  = 2;

  function automatic int max_pend(input int pend_w);
    return (1 << pend_w) - 1;
  endfunction

endpackage

// File: rtl/arb_pend_cnt.sv
// Per-port pending-job counter with ready/overflow detect.
// Optional starvation wait counter built when ARB_REQ_STARVE_MON_EN is defined.
module arb_pend_cnt
  import arb_req_pkg::*;
#(
  parameter int PEND_W       = 3,
  parameter int STARVE_LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic job_valid_i,
  input  logic dec_i,
  input  logic req_i,
  output logic job_ready_o,
  output logic pend_nz_o,
  output logic pend_nxt_nz_o,
  output logic overflow_o,
  output logic starve_o
);

  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(max_pend(PEND_W));

  logic [PEND_W-1:0] pend_q;
  logic [PEND_W-1:0] pend_d;
  logic              inc;

  assign job_ready_o = !rst_i && (pend_q != PEND_MAX);
  assign inc         = job_valid_i && job_ready_o;
  assign overflow_o  = job_valid_i && !job_ready_o;

  // A job arriving on the same edge as a grant cancels out.
  always_comb begin
    pend_d = pend_q;
    if (inc && !dec_i) begin
      pend_d = pend_q + PEND_W'(1);
    end else if (!inc && dec_i) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend_nz_o     = (pend_q != '0);
  assign pend_nxt_nz_o = (pend_d != '0);

`ifdef ARB_REQ_STARVE_MON_EN
  localparam int                WAIT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  logic [WAIT_W-1:0] wait_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_q <= '0;
    end else if (dec_i || (pend_d == '0)) begin
      wait_q <= '0;
    end else if (req_i && (wait_q != WAIT_MAX)) begin
      wait_q <= wait_q + WAIT_W'(1);
    end
  end

  assign starve_o = (wait_q == WAIT_MAX);
`else
  logic unused_starve;
  assign unused_starve = req_i ^ (STARVE_LIMIT > 0);
  assign starve_o      = 1'b0;
`endif

endmodule

// File: rtl/arb_req_gen.sv
// Requester front end for the fixed-priority arbiter: queues jobs, requests, runs bursts.
// Starvation monitor is enabled by defining ARB_REQ_STARVE_MON_EN.
module arb_req_gen
  import arb_req_pkg::*;
#(
  parameter int NUM_PORTS    = 5,
  parameter int PEND_W       = 3,
  parameter int BURST_LEN    = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_PORTS-1:0]         job_valid_i,
  output logic [NUM_PORTS-1:0]         job_ready_o,
  output logic [NUM_PORTS-1:0]         req_o,
  input  logic [NUM_PORTS-1:0]         gnt_i,
  output logic                         busy_o,
  output logic [$clog2(NUM_PORTS)-1:0] owner_o,
  output logic                         beat_o,
  output logic                         last_o,
  output logic [2:0]                   err_o,
  output logic [NUM_PORTS-1:0]         starve_o
);

  localparam int                   OWN_W     = $clog2(NUM_PORTS);
  localparam int                   BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [NUM_PORTS-1:0] PORT_ONE  = {{(NUM_PORTS-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [OWN_W-1:0]       owner_q, owner_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [NUM_PORTS-1:0]   req_q, req_d;
  logic [2:0]             err_q, err_d;

  logic [NUM_PORTS-1:0]   pend_nz;
  logic [NUM_PORTS-1:0]   pend_nxt_nz;
  logic [NUM_PORTS-1:0]   overflow;
  logic [NUM_PORTS-1:0]   dec;
  logic                   gnt_any;
  logic                   gnt_multi;
  logic                   accept;
  logic [OWN_W-1:0]       gnt_idx;

  assign gnt_any   = (gnt_i != '0);
  assign gnt_multi = ((gnt_i & (gnt_i - PORT_ONE)) != '0);
  assign accept    = (state_q == IDLE) && gnt_any && !gnt_multi && ((gnt_i & pend_nz) != '0);
  assign dec       = accept ? gnt_i : '0;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt_i[i]) begin
        gnt_idx = OWN_W'(i);
      end
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    arb_pend_cnt #(
      .PEND_W       (PEND_W),
      .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pend (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .job_valid_i   (job_valid_i[i]),
      .dec_i         (dec[i]),
      .req_i         (req_q[i]),
      .job_ready_o   (job_ready_o[i]),
      .pend_nz_o     (pend_nz[i]),
      .pend_nxt_nz_o (pend_nxt_nz[i]),
      .overflow_o    (overflow[i]),
      .starve_o      (starve_o[i])
    );
  end

  // req_o tracks next-cycle pending state in IDLE and is forced low for the whole burst.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    req_d   = req_q;
    err_d   = err_q;
    if (overflow != '0) begin
      err_d[ERR_OVERFLOW] = 1'b1;
    end
    case (state_q)
      IDLE: begin
        req_d = pend_nxt_nz;
        if (gnt_multi) begin
          err_d[ERR_MULTI_GNT] = 1'b1;
        end else if (accept) begin
          state_d = BURST;
          owner_d = gnt_idx;
          beat_d  = '0;
          req_d   = '0;
        end else if (gnt_any) begin
          err_d[ERR_IDLE_GNT] = 1'b1;
        end
      end
      BURST: begin
        req_d = '0;
        if (beat_q == LAST_BEAT) begin
          state_d = IDLE;
          req_d   = pend_nxt_nz;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      beat_q  <= '0;
      req_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  assign req_o   = req_q;
  assign owner_o = owner_q;
  assign err_o   = err_q;
  assign busy_o  = (state_q == BURST);
  assign beat_o  = (state_q == BURST);
  assign last_o  = (state_q == BURST) && (beat_q == LAST_BEAT);

endmodule
